// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter (LSL/LSR/ASR/ROR) with valid/ready flow control and STAGES register slices.
// Optional registered carry_out port is enabled by defining SHIFTER_CARRY_OUT_EN.
module shifter_pipe #(
    parameter int WIDTH = 16,
    parameter int STAGES = 2,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shift_amt,
    input  logic [1:0]         op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   data_out
`ifdef SHIFTER_CARRY_OUT_EN
    ,
    output logic               carry_out
`endif
);
    localparam int BASE = SHAMT_W / STAGES;
    localparam int REM  = SHAMT_W % STAGES;

    logic advance;
    genvar gi, gj;

    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_slice
            // Leftover mux levels go to the earliest slices.
            localparam int NLEV = BASE + ((gi < REM) ? 1 : 0);
            localparam int LO   = gi * BASE + ((gi < REM) ? gi : REM);
            localparam int IN_W = SHAMT_W - LO;

            logic             src_valid;
            logic [WIDTH-1:0] src_data;
            logic [IN_W-1:0]  src_amt;
            logic [1:0]       src_op;
            logic             valid_reg;
            logic [WIDTH-1:0] data_reg;
`ifdef SHIFTER_CARRY_OUT_EN
            logic             src_carry;
            logic             carry_reg;
`endif

            if (gi == 0) begin : g_src_in
                assign src_valid = in_valid;
                assign src_data  = data_in;
                assign src_amt   = shift_amt;
                assign src_op    = op;
`ifdef SHIFTER_CARRY_OUT_EN
                assign src_carry = 1'b0;
`endif
            end else begin : g_src_prev
                assign src_valid = g_slice[gi-1].valid_reg;
                assign src_data  = g_slice[gi-1].data_reg;
                assign src_amt   = g_slice[gi-1].g_fwd.amt_reg;
                assign src_op    = g_slice[gi-1].g_fwd.op_reg;
`ifdef SHIFTER_CARRY_OUT_EN
                assign src_carry = g_slice[gi-1].carry_reg;
`endif
            end

            for (gj = 0; gj < NLEV; gj++) begin : g_level
                localparam int SH = 1 << (LO + gj);

                logic [WIDTH-1:0] lvl_in;
                logic [WIDTH-1:0] shifted;
                logic [WIDTH-1:0] lvl_out;

                if (gj == 0) begin : g_first
                    assign lvl_in = src_data;
                end else begin : g_next
                    assign lvl_in = g_level[gj-1].lvl_out;
                end

                always_comb begin
                    shifted = lvl_in;
                    case (src_op)
                        2'b00:   shifted = lvl_in << SH;
                        2'b01:   shifted = lvl_in >> SH;
                        2'b10:   shifted = $unsigned($signed(lvl_in) >>> SH);
                        default: shifted = (lvl_in >> SH) | (lvl_in << (WIDTH - SH));
                    endcase
                end

                assign lvl_out = src_amt[gj] ? shifted : lvl_in;

`ifdef SHIFTER_CARRY_OUT_EN
                // The last active level's outgoing bit is the overall last bit shifted out.
                logic lvl_cin;
                logic out_bit;
                logic lvl_cout;

                if (gj == 0) begin : g_cfirst
                    assign lvl_cin = src_carry;
                end else begin : g_cnext
                    assign lvl_cin = g_level[gj-1].lvl_cout;
                end

                assign out_bit  = (src_op == 2'b00) ? lvl_in[WIDTH-SH] : lvl_in[SH-1];
                assign lvl_cout = src_amt[gj] ? out_bit : lvl_cin;
`endif
            end

            always_ff @(posedge Clock) begin
                if (Reset) begin
                    valid_reg <= 1'b0;
                    data_reg  <= '0;
`ifdef SHIFTER_CARRY_OUT_EN
                    carry_reg <= 1'b0;
`endif
                end else if (advance) begin
                    valid_reg <= src_valid;
                    if (src_valid) begin
                        data_reg  <= g_level[NLEV-1].lvl_out;
`ifdef SHIFTER_CARRY_OUT_EN
                        carry_reg <= g_level[NLEV-1].lvl_cout;
`endif
                    end
                end
            end

            // Only the shift-amount bits still needed downstream travel on.
            if (gi < STAGES - 1) begin : g_fwd
                logic [IN_W-NLEV-1:0] amt_reg;
                logic [1:0]           op_reg;

                always_ff @(posedge Clock) begin
                    if (Reset) begin
                        amt_reg <= '0;
                        op_reg  <= '0;
                    end else if (advance && src_valid) begin
                        amt_reg <= src_amt[IN_W-1:NLEV];
                        op_reg  <= src_op;
                    end
                end
            end
        end
    endgenerate

    assign out_valid = g_slice[STAGES-1].valid_reg;
    assign data_out  = g_slice[STAGES-1].data_reg;
    assign advance   = out_ready | ~out_valid;
    assign in_ready  = advance;
`ifdef SHIFTER_CARRY_OUT_EN
    assign carry_out = g_slice[STAGES-1].carry_reg;
`endif

endmodule
